// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared encodings for the multicycle RV32I controller: FSM
//               states, opcodes, ALU operation codes and mux select values.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } statetype;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Internal ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage
`default_nettype wire

// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
// Module      : main_fsm
// Description : Instruction sequencer for the multicycle controller. Holds
//               the state register and produces the per-state datapath
//               controls, the PC write decision and the ALU operation class.
// Revision    : 1.0 - initial release
// ============================================================================
module main_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       funct3_0,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       InstrRetire,
  output logic       IllegalOp,
  output logic [1:0] ALUOp
);

  statetype state;
  statetype next_state;

  logic pc_update;
  logic branch;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic retire_raw;
  logic illegal_raw;

  // State register; reset always returns to FETCH
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Next-state and per-state control table
  always_comb begin
    next_state    = state;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    retire_raw    = 1'b0;
    illegal_raw   = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_WD;
    ALUOp         = ALUOP_ADD;

    case (state)
      FETCH: begin
        ir_write_raw = 1'b1;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_FOUR;
        ALUOp        = ALUOP_ADD;
        ResultSrc    = RES_ALURESULT;
        pc_update    = 1'b1;
        next_state   = DECODE;
      end
      DECODE: begin
        // Precompute the branch/jump target into ALUOut
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECR;
          OP_ITYPE:     next_state = EXECI;
          OP_JAL:       next_state = JAL;
          OP_BRANCH:    next_state = BEQ;
          default: begin
            illegal_raw = 1'b1;
            next_state  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_ADD;
        next_state = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        ResultSrc  = RES_ALUOUT;
        next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        next_state    = FETCH;
      end
      MEMWRITE: begin
        AdrSrc        = 1'b1;
        ResultSrc     = RES_ALUOUT;
        mem_write_raw = 1'b1;
        retire_raw    = 1'b1;
        next_state    = FETCH;
      end
      EXECR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_WD;
        ALUOp      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        ResultSrc     = RES_ALUOUT;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        next_state    = FETCH;
      end
      JAL: begin
        // Jump to ALUOut target while computing the link value OldPC+4
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ALUOp      = ALUOP_ADD;
        ResultSrc  = RES_ALUOUT;
        pc_update  = 1'b1;
        next_state = ALUWB;
      end
      BEQ: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_WD;
        ALUOp      = ALUOP_SUB;
        ResultSrc  = RES_ALUOUT;
        branch     = 1'b1;
        retire_raw = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  // Write enables and status flags; reset suppresses all of them so an
  // aborted instruction leaves no architectural side effect
  always_comb begin
    PCWrite     = ~reset & (pc_update | (branch & (Zero ^ funct3_0)));
    MemWrite    = ~reset & mem_write_raw;
    IRWrite     = ~reset & ir_write_raw;
    RegWrite    = ~reset & reg_write_raw;
    InstrRetire = ~reset & retire_raw;
    IllegalOp   = ~reset & illegal_raw;
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Control unit for a multicycle RV32I datapath (lw, sw, R-type,
//               I-type ALU, beq/bne, jal). Wraps the sequencer and adds the
//               ALU operation and immediate format decoders.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       RegWrite,
  output logic       InstrRetire,
  output logic       IllegalOp
);

  logic [1:0] alu_op;

  main_fsm u_main_fsm (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3_0    (funct3[0]),
    .Zero        (Zero),
    .PCWrite     (PCWrite),
    .AdrSrc      (AdrSrc),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .ResultSrc   (ResultSrc),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .RegWrite    (RegWrite),
    .InstrRetire (InstrRetire),
    .IllegalOp   (IllegalOp),
    .ALUOp       (alu_op)
  );

  // ALU operation decode; op[5] separates R-type sub from I-type addi
  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  ALUControl = ALU_SLL;
          3'b010:  ALUControl = ALU_SLT;
          3'b011:  ALUControl = ALU_SLTU;
          3'b100:  ALUControl = ALU_XOR;
          3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ALUControl = ALU_OR;
          default: ALUControl = ALU_AND;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

  // Immediate format decode, purely from the opcode in every state
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LW, OP_ITYPE: ImmSrc = IMM_I;
      OP_SW:           ImmSrc = IMM_S;
      OP_BRANCH:       ImmSrc = IMM_B;
      OP_JAL:          ImmSrc = IMM_J;
      default:         ImmSrc = IMM_I;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller: directed table
//               of instructions, reset/abort sequences and randomized
//               instruction streams checked against a cycle-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrRetire, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .InstrRetire(InstrRetire), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [3:0] alu;
    logic       regw;
    logic       ret;
    logic       ill;
  } outs_t;

  outs_t act;
  // Snapshot of every DUT output in one comparable word
  always_comb begin
    act.pcw  = PCWrite;   act.adr  = AdrSrc;   act.memw = MemWrite;
    act.irw  = IRWrite;   act.res  = ResultSrc; act.srca = ALUSrcA;
    act.srcb = ALUSrcB;   act.imm  = ImmSrc;   act.alu  = ALUControl;
    act.regw = RegWrite;  act.ret  = InstrRetire; act.ill = IllegalOp;
  end

  // ---------------- reference model: instruction -> list of cycles ----------
  typedef enum int {K_LW, K_SW, K_R, K_I, K_JAL, K_BR, K_ILL} kind_t;

  function automatic kind_t kind_of(input logic [6:0] o);
    case (o)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1101111: return K_JAL;
      7'b1100011: return K_BR;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic int latency_of(input logic [6:0] o);
    case (kind_of(o))
      K_LW:    return 5;
      K_BR:    return 3;
      K_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] alu_of_funct(input logic [2:0] f, input logic f7, input logic op5);
    case (f)
      3'd0: return (f7 && op5) ? 4'd1 : 4'd0;
      3'd1: return 4'd6;
      3'd2: return 4'd5;
      3'd3: return 4'd8;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd7;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Expected outputs for cycle c (0 = fetch) of one instruction
  function automatic outs_t model(input logic [6:0] o, input logic [2:0] f,
                                  input logic f7, input logic z, input int c);
    outs_t e = '0;
    kind_t k = kind_of(o);
    case (k)
      K_SW:    e.imm = 2'd1;
      K_BR:    e.imm = 2'd2;
      K_JAL:   e.imm = 2'd3;
      default: e.imm = 2'd0;
    endcase
    if (c == 0) begin
      e.irw = 1; e.pcw = 1; e.srcb = 2'd2; e.res = 2'd2;
    end else if (c == 1) begin
      e.srca = 2'd1; e.srcb = 2'd1; e.ill = (k == K_ILL);
    end else if (c == 2) begin
      case (k)
        K_LW, K_SW: begin e.srca = 2'd2; e.srcb = 2'd1; end
        K_R:   begin e.srca = 2'd2; e.srcb = 2'd0; e.alu = alu_of_funct(f, f7, o[5]); end
        K_I:   begin e.srca = 2'd2; e.srcb = 2'd1; e.alu = alu_of_funct(f, f7, o[5]); end
        K_JAL: begin e.srca = 2'd1; e.srcb = 2'd2; e.pcw = 1; end
        K_BR:  begin e.srca = 2'd2; e.alu = 4'd1; e.pcw = z ^ f[0]; e.ret = 1; end
        default: ;
      endcase
    end else if (c == 3) begin
      case (k)
        K_LW: e.adr = 1;
        K_SW: begin e.adr = 1; e.memw = 1; e.ret = 1; end
        K_R, K_I, K_JAL: begin e.regw = 1; e.ret = 1; end
        default: ;
      endcase
    end else if (c == 4 && k == K_LW) begin
      e.res = 2'd1; e.regw = 1; e.ret = 1;
    end
    return e;
  endfunction

  // ---------------- checking helpers ----------------------------------------
  task automatic check(input string nm, input outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h required %05h (pcw adr memw irw res srca srcb imm alu regw ret ill)",
               nm, act, exp);
    end
  endtask

  task automatic check_field(input string nm, input logic [3:0] got, input logic [3:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  // Every write enable and status flag must be low while reset is high
  task automatic check_gated(input string nm);
    n_checks++;
    if ({PCWrite, IRWrite, MemWrite, RegWrite, InstrRetire, IllegalOp} !== 6'b0) begin
      n_errors++;
      $display("FAIL %s: got pcw/irw/memw/regw/ret/ill=%b required 000000", nm,
               {PCWrite, IRWrite, MemWrite, RegWrite, InstrRetire, IllegalOp});
    end
  endtask

  // Drive one instruction for ncyc cycles, checking each against the model.
  // Entered and left just after a rising edge.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic f7,
                           input logic z, input int ncyc, input string nm,
                           input bit tab, input logic [3:0] t_alu,
                           input logic t_pcw, input logic [1:0] t_imm);
    op = o; funct3 = f; funct7b5 = f7; Zero = z;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", nm, c + 1), model(o, f, f7, z, c));
      if (tab && c == 2) begin
        check_field({nm, "_alu_c3"}, ALUControl, t_alu);
        check_field({nm, "_pcw_c3"}, {3'b0, PCWrite}, {3'b0, t_pcw});
        check_field({nm, "_imm_c3"}, {2'b0, ImmSrc}, {2'b0, t_imm});
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- directed table ------------------------------------------
  typedef struct {
    string      nm;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    int         lat;
    logic [3:0] alu_c3;
    logic       pcw_c3;
    logic [1:0] imm;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 5, 4'b0000, 1'b0, 2'b00});
    vecs.push_back('{"sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 4, 4'b0000, 1'b0, 2'b01});
    vecs.push_back('{"sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 4, 4'b0001, 1'b0, 2'b00});
    vecs.push_back('{"add",     7'b0110011, 3'b000, 1'b0, 1'b0, 4, 4'b0000, 1'b0, 2'b00});
    vecs.push_back('{"addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 4, 4'b0000, 1'b0, 2'b00});
    vecs.push_back('{"srai",    7'b0010011, 3'b101, 1'b1, 1'b0, 4, 4'b1001, 1'b0, 2'b00});
    vecs.push_back('{"srl",     7'b0110011, 3'b101, 1'b0, 1'b1, 4, 4'b0111, 1'b0, 2'b00});
    vecs.push_back('{"slt",     7'b0110011, 3'b010, 1'b0, 1'b0, 4, 4'b0101, 1'b0, 2'b00});
    vecs.push_back('{"sltiu",   7'b0010011, 3'b011, 1'b0, 1'b0, 4, 4'b1000, 1'b0, 2'b00});
    vecs.push_back('{"xor",     7'b0110011, 3'b100, 1'b0, 1'b0, 4, 4'b0100, 1'b0, 2'b00});
    vecs.push_back('{"or",      7'b0110011, 3'b110, 1'b0, 1'b0, 4, 4'b0011, 1'b0, 2'b00});
    vecs.push_back('{"andi",    7'b0010011, 3'b111, 1'b0, 1'b0, 4, 4'b0010, 1'b0, 2'b00});
    vecs.push_back('{"sll",     7'b0110011, 3'b001, 1'b0, 1'b0, 4, 4'b0110, 1'b0, 2'b00});
    vecs.push_back('{"beq_tk",  7'b1100011, 3'b000, 1'b0, 1'b1, 3, 4'b0001, 1'b1, 2'b10});
    vecs.push_back('{"beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, 3, 4'b0001, 1'b0, 2'b10});
    vecs.push_back('{"bne_tk",  7'b1100011, 3'b001, 1'b0, 1'b0, 3, 4'b0001, 1'b1, 2'b10});
    vecs.push_back('{"bne_nt",  7'b1100011, 3'b001, 1'b0, 1'b1, 3, 4'b0001, 1'b0, 2'b10});
    vecs.push_back('{"jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 4, 4'b0000, 1'b1, 2'b11});
    vecs.push_back('{"illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 2, 4'b0000, 1'b0, 2'b00});
  end

  // ---------------- main sequence -------------------------------------------
  initial begin
    logic [6:0] legal_ops[6];
    legal_ops[0] = 7'b0000011; legal_ops[1] = 7'b0100011; legal_ops[2] = 7'b0110011;
    legal_ops[3] = 7'b0010011; legal_ops[4] = 7'b1101111; legal_ops[5] = 7'b1100011;

    reset = 1'b1; op = 7'b0000011; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0;
    @(posedge clk); #1;

    // Reset held three cycles: no enables
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_gated($sformatf("reset_hold_%0d", i));
      @(posedge clk); #1;
    end
    reset = 1'b0;

    // Directed table; each entry's first cycle also proves the previous one
    // returned to FETCH
    foreach (vecs[i])
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero, vecs[i].lat,
                vecs[i].nm, vecs[i].lat >= 3, vecs[i].alu_c3, vecs[i].pcw_c3, vecs[i].imm);

    // Reset during MEMREAD of lw aborts it, then FETCH follows
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3, "abort_lw", 1'b0, 4'd0, 1'b0, 2'd0);
    reset = 1'b1;
    @(negedge clk); check_gated("abort_memread");
    @(posedge clk); #1; reset = 1'b0;
    run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 4, "after_abort_rd", 1'b0, 4'd0, 1'b0, 2'd0);

    // Reset during MEMWB must suppress the register write
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 4, "abort_lw_wb", 1'b0, 4'd0, 1'b0, 2'd0);
    reset = 1'b1;
    @(negedge clk); check_gated("abort_memwb");
    @(posedge clk); #1; reset = 1'b0;
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3, "abort_sw", 1'b0, 4'd0, 1'b0, 2'd0);

    // Reset during MEMWRITE must suppress the store
    reset = 1'b1;
    @(negedge clk); check_gated("abort_memwrite");
    @(posedge clk); #1; reset = 1'b0;

    // Reset during DECODE of an illegal op must suppress IllegalOp
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1, "abort_ill", 1'b0, 4'd0, 1'b0, 2'd0);
    reset = 1'b1;
    @(negedge clk); check_gated("abort_decode_ill");
    @(posedge clk); #1; reset = 1'b0;
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 3, "after_abort_ill", 1'b0, 4'd0, 1'b0, 2'd0);

    // Randomized instruction stream against the model
    for (int n = 0; n < 150; n++) begin
      logic [6:0] o;
      int sel;
      sel = $urandom_range(0, 7);
      o = (sel < 6) ? legal_ops[sel] : 7'($urandom);
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), latency_of(o),
                $sformatf("rand%0d", n), 1'b0, 4'd0, 1'b0, 2'd0);
    end

    // Final instruction must start in FETCH
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1, "final_fetch", 1'b0, 4'd0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
